// File: rtl/mac_lane_accumulator.sv
// -----------------------------------------------------------------------------
// mac_lane_accumulator
//
// Multi-lane multiply-accumulate engine. Each lane multiplies an activation
// (unsigned or two's complement, chosen per job) by a signed weight and sums
// the products over a programmable number of beats. A two-stage pipeline
// (product register, then accumulator) sits under a four-state control FSM
// (IDLE -> ACC -> DRAIN -> DONE). Valid/ready handshakes are used on both
// the input and the output side.
//
// Parameters:
//   bw       width of each activation / weight element
//   psum_bw  width of each lane accumulator and output element
//   lanes    number of parallel lanes
//   len_bw   width of the acc_len beat-count field
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   a_signed   activation signedness, taken from the first beat of a job
//   in_valid   input beat valid
//   in_ready   block can accept a beat (IDLE or ACC)
//   a          activations, lane i = a[i*bw +: bw]
//   b          signed weights, lane i = b[i*bw +: bw]
//   acc_len    beats per job, taken from the first beat; 0 means 1
//   out_valid  accumulated result valid (DONE)
//   out_ready  consumer accepts the result
//   out        lane accumulators, lane i = out[i*psum_bw +: psum_bw]
//   busy       high in any state other than IDLE
//   sat_flag   (MAC_SATURATE_EN only) per lane, lane saturated during the job
//
// Build option:
//   MAC_SATURATE_EN  when defined, lane adds saturate to the signed psum_bw
//                    limits and the sat_flag port is present; otherwise the
//                    adds wrap modulo 2^psum_bw.
// -----------------------------------------------------------------------------
module mac_lane_accumulator #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int lanes   = 4,
    parameter int len_bw  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a_signed,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [lanes*bw-1:0]        a,
    input  logic [lanes*bw-1:0]        b,
    input  logic [len_bw-1:0]          acc_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [lanes*psum_bw-1:0]   out,
    output logic                       busy
`ifdef MAC_SATURATE_EN
    ,
    output logic [lanes-1:0]           sat_flag
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                w_accept;
    logic                w_out_fire;
    logic                w_a_signed_eff;
    logic                r_a_signed;
    logic                r_prod_vld;
    logic [len_bw-1:0]   r_count;
    logic [len_bw-1:0]   r_len;
    logic [len_bw-1:0]   w_len_in;
    logic [len_bw-1:0]   w_count_inc;

    // A programmed length of zero runs a single beat.
    assign w_len_in       = (acc_len == '0) ? len_bw'(1) : acc_len;
    assign w_count_inc    = r_count + len_bw'(1);
    assign w_accept       = in_valid && in_ready;
    assign w_out_fire     = out_valid && out_ready;

    // On the first beat the live a_signed applies; later beats use the copy
    // latched with that first beat.
    assign w_a_signed_eff = (r_state == S_IDLE) ? a_signed : r_a_signed;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // NOTE: clocked state is updated with non-blocking (<=) assignments so all
    // registers sample the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = (w_len_in == len_bw'(1)) ? S_DRAIN : S_ACC;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid && (w_count_inc == r_len)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last product is being added into the accumulators.
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Job bookkeeping: beat counter, latched length and signedness
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_len      <= '0;
            r_a_signed <= 1'b0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                r_count    <= len_bw'(1);
                r_len      <= w_len_in;
                r_a_signed <= a_signed;
            end else begin
                r_count    <= w_count_inc;
            end
        end else if (w_out_fire) begin
            r_count <= '0;
        end
    end

    // Stage-1 valid: the accepting edge marks the product registers as live.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod_vld <= 1'b0;
        end else begin
            r_prod_vld <= w_accept;
        end
    end

    // -------------------------------------------------------------------------
    // Per-lane datapath
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < lanes; i++) begin : g_lane
        logic [psum_bw-1:0] w_a_ext;
        logic [psum_bw-1:0] w_b_ext;
        logic [psum_bw-1:0] w_prod;
        logic [psum_bw-1:0] w_acc_nxt;
        logic [psum_bw-1:0] r_prod;
        logic [psum_bw-1:0] r_acc;

        // Both operands are extended straight to psum_bw; the low psum_bw bits
        // of the unsigned product equal the sign-extended signed product.
        assign w_a_ext = {{(psum_bw-bw){w_a_signed_eff & a[i*bw+bw-1]}}, a[i*bw +: bw]};
        assign w_b_ext = {{(psum_bw-bw){b[i*bw+bw-1]}}, b[i*bw +: bw]};
        assign w_prod  = w_a_ext * w_b_ext;

`ifdef MAC_SATURATE_EN
        logic               r_sat;
        logic               w_sat_nxt;
        logic [psum_bw:0]   w_sum;

        // One guard bit: the top two bits of the sum differ on overflow.
        assign w_sum = {r_acc[psum_bw-1], r_acc} + {r_prod[psum_bw-1], r_prod};

        always_comb begin
            w_acc_nxt = w_sum[psum_bw-1:0];
            w_sat_nxt = r_sat;
            if (r_sat) begin
                // A saturated lane holds its limit for the rest of the job.
                w_acc_nxt = r_acc;
            end else if (w_sum[psum_bw] != w_sum[psum_bw-1]) begin
                w_sat_nxt = 1'b1;
                w_acc_nxt = w_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                           : {1'b0, {(psum_bw-1){1'b1}}};
            end
        end

        always_ff @(posedge clk) begin
            if (reset || w_out_fire) begin
                r_sat <= 1'b0;
            end else if (r_prod_vld) begin
                r_sat <= w_sat_nxt;
            end
        end

        assign sat_flag[i] = r_sat;
`else
        assign w_acc_nxt = r_acc + r_prod;
`endif

        // NOTE: the product and accumulator registers are cleared by reset so a
        // stale partial sum can never leak into the next job.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_prod <= '0;
                r_acc  <= '0;
            end else begin
                if (w_accept) begin
                    r_prod <= w_prod;
                end
                if (w_out_fire) begin
                    r_acc <= '0;
                end else if (r_prod_vld) begin
                    r_acc <= w_acc_nxt;
                end
            end
        end

        assign out[i*psum_bw +: psum_bw] = r_acc;
    end

endmodule

// File: tb/tb_mac_lane_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mac_lane_accumulator
//
// Drives two copies of mac_lane_accumulator in lockstep (psum_bw = 16 and
// psum_bw = 8) from shared inputs, and compares each job against an integer
// reference model of the lane arithmetic (per-beat products summed with wrap
// or saturation at the output width). Works with and without MAC_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_mac_lane_accumulator;

    localparam int BW     = 4;
    localparam int LANES  = 4;
    localparam int LEN_BW = 8;
    localparam int PW     = 16;
    localparam int PW8    = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   a_signed;
    logic                   in_valid;
    logic                   out_ready;
    logic [LANES*BW-1:0]    a;
    logic [LANES*BW-1:0]    b;
    logic [LEN_BW-1:0]      acc_len;

    logic                   in_ready,  out_valid,  busy;
    logic                   in_ready8, out_valid8, busy8;
    logic [LANES*PW-1:0]    out;
    logic [LANES*PW8-1:0]   out8;
`ifdef MAC_SATURATE_EN
    logic [LANES-1:0]       sat_flag;
    logic [LANES-1:0]       sat_flag8;
`endif

    int checks = 0;
    int errors = 0;

    // Job description shared between the test tasks and run_job.
    logic [LANES*BW-1:0]    q_a[$];
    logic [LANES*BW-1:0]    q_b[$];
    bit                     q_pat[$];
    logic [LANES*PW-1:0]    last_out;
    logic [LANES*PW8-1:0]   last_out8;
`ifdef MAC_SATURATE_EN
    logic [LANES-1:0]       last_sat8;
`endif

    always #5 clk = ~clk;

    mac_lane_accumulator #(.bw(BW), .psum_bw(PW), .lanes(LANES), .len_bw(LEN_BW)) dut (
        .clk(clk), .reset(reset), .a_signed(a_signed), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .acc_len(acc_len),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
`ifdef MAC_SATURATE_EN
        , .sat_flag(sat_flag)
`endif
    );

    mac_lane_accumulator #(.bw(BW), .psum_bw(PW8), .lanes(LANES), .len_bw(LEN_BW)) dut8 (
        .clk(clk), .reset(reset), .a_signed(a_signed), .in_valid(in_valid),
        .in_ready(in_ready8), .a(a), .b(b), .acc_len(acc_len),
        .out_valid(out_valid8), .out_ready(out_ready), .out(out8), .busy(busy8)
`ifdef MAC_SATURATE_EN
        , .sat_flag(sat_flag8)
`endif
    );

    // ---------------------------------------------------------------- model --
    function automatic int elem(input logic [LANES*BW-1:0] v, input int lane, input bit sgn);
        logic [BW-1:0] x;
        x = v[lane*BW +: BW];
        return sgn ? int'($signed(x)) : int'(x);
    endfunction

    function automatic int wrap_to(input int v, input int w);
        int m;
        int r;
        m = 1 << w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Final value of one lane for the queued job at output width w.
    function automatic int model_lane(input int w, input int lane, input bit sgn, output bit sat);
        int acc;
        int p;
`ifdef MAC_SATURATE_EN
        int s;
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
`endif
        acc = 0;
        sat = 1'b0;
        foreach (q_a[k]) begin
            p = wrap_to(elem(q_a[k], lane, sgn) * elem(q_b[k], lane, 1'b1), w);
`ifdef MAC_SATURATE_EN
            if (!sat) begin
                s = acc + p;
                if (s > hi) begin
                    acc = hi;
                    sat = 1'b1;
                end else if (s < lo) begin
                    acc = lo;
                    sat = 1'b1;
                end else begin
                    acc = s;
                end
            end
`else
            acc = wrap_to(acc + p, w);
`endif
        end
        return acc;
    endfunction

    // -------------------------------------------------------------- helpers --
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset     = 1'b0;
    endtask

    // Runs the queued job: feeds the beats (optionally with bubbles), checks
    // the result latency, the result itself, stability under `hold` cycles of
    // backpressure, and the output handshake. Clears the job queues at the end.
    task automatic run_job(input int len_prog, input bit sgn, input bit rand_bub, input int hold);
        logic [LANES*PW-1:0]  e16;
        logic [LANES*PW8-1:0] e8;
`ifdef MAC_SATURATE_EN
        logic [LANES-1:0]     es16;
        logic [LANES-1:0]     es8;
`endif
        int  n;
        int  idx;
        int  pi;
        int  budget;
        bit  first_done;
        bit  accepted;

        for (int l = 0; l < LANES; l++) begin
            bit st;
            int v;
            v = model_lane(PW, l, sgn, st);
            e16[l*PW +: PW] = PW'(v);
`ifdef MAC_SATURATE_EN
            es16[l] = st;
`endif
            v = model_lane(PW8, l, sgn, st);
            e8[l*PW8 +: PW8] = PW8'(v);
`ifdef MAC_SATURATE_EN
            es8[l] = st;
`endif
        end

        n = q_a.size();
        idx = 0;
        pi = 0;
        budget = 0;
        first_done = 1'b0;
        while (idx < n && budget < 2000) begin
            if (pi < q_pat.size())  in_valid = q_pat[pi];
            else if (rand_bub)      in_valid = ($urandom_range(0, 3) != 0);
            else                    in_valid = 1'b1;
            pi++;
            a = in_valid ? q_a[idx] : (LANES*BW)'($urandom);
            b = in_valid ? q_b[idx] : (LANES*BW)'($urandom);
            if (first_done) begin
                // Must be ignored until the next job starts.
                acc_len  = LEN_BW'($urandom);
                a_signed = 1'($urandom);
            end else begin
                acc_len  = LEN_BW'(len_prog);
                a_signed = sgn;
            end
            // Ignored while no result is pending.
            out_ready = 1'($urandom);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL feed_in_ready beat %0d: got %b want 1", idx, in_ready);
            end
            accepted = in_valid && in_ready;
            tick();
            budget++;
            if (accepted) begin
                idx++;
                first_done = 1'b1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (idx < n) begin
            errors++;
            $display("FAIL feed_timeout: %0d of %0d beats accepted", idx, n);
            do_reset();
            q_a.delete(); q_b.delete(); q_pat.delete();
            return;
        end

        // Right after the final accepting edge the block is draining.
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_state: out_valid=%b in_ready=%b busy=%b want 0 0 1", out_valid, in_ready, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_latency: out_valid=%b one edge after drain, want 1", out_valid);
            budget = 0;
            while (out_valid !== 1'b1 && budget < 20) begin
                tick();
                budget++;
            end
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL result_timeout: out_valid never rose");
                do_reset();
                q_a.delete(); q_b.delete(); q_pat.delete();
                return;
            end
        end

        checks++;
        if (out !== e16) begin
            errors++;
            $display("FAIL out16: got %h want %h", out, e16);
        end
        checks++;
        if (out8 !== e8) begin
            errors++;
            $display("FAIL out8: got %h want %h", out8, e8);
        end
`ifdef MAC_SATURATE_EN
        checks++;
        if (sat_flag !== es16 || sat_flag8 !== es8) begin
            errors++;
            $display("FAIL sat_flag: got %b/%b want %b/%b", sat_flag, sat_flag8, es16, es8);
        end
        last_sat8 = sat_flag8;
`endif
        last_out  = out;
        last_out8 = out8;

        // Backpressure: result held, nothing accepted even with in_valid high.
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = (LANES*BW)'($urandom);
            b = (LANES*BW)'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== e16) begin
                errors++;
                $display("FAIL hold_%0d: out_valid=%b in_ready=%b out=%h want 1 0 %h", h, out_valid, in_ready, out, e16);
            end
        end

        // Output handshake with a competing input beat that must be refused.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = (LANES*BW)'($urandom);
        b = (LANES*BW)'($urandom);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL handshake_in_ready: got %b want 0", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: out_valid=%b out=%h in_ready=%b busy=%b want 0 0 1 0", out_valid, out, in_ready, busy);
        end
        q_a.delete();
        q_b.delete();
        q_pat.delete();
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            q_a.push_back((LANES*BW)'($urandom));
            q_b.push_back((LANES*BW)'($urandom));
        end
    endtask

    // ---------------------------------------------------------------- tests --
    task automatic test_reset;
        a = '0; b = '0; acc_len = '0; a_signed = 1'b0;
        do_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (out !== '0 || out8 !== '0) begin
            errors++;
            $display("FAIL reset_out: got %h/%h want 0", out, out8);
        end
    endtask

    task automatic test_unsigned_len3;
        for (int k = 0; k < 3; k++) begin
            q_a.push_back({LANES{4'hF}});
            q_b.push_back({LANES{4'h8}});
        end
        run_job(3, 1'b0, 1'b0, 0);
        checks++;
        if (last_out !== {LANES{16'hFE98}}) begin
            errors++;
            $display("FAIL unsigned_len3: got %h want %h", last_out, {LANES{16'hFE98}});
        end
    endtask

    task automatic test_signed_len1;
        for (int len = 1; len >= 0; len--) begin
            q_a.push_back({4'h0, 4'h0, 4'h8, 4'hF});
            q_b.push_back({4'h0, 4'h0, 4'h7, 4'h8});
            run_job(len, 1'b1, 1'b0, 0);
            checks++;
            if (last_out !== {16'h0000, 16'h0000, 16'hFFC8, 16'h0008}) begin
                errors++;
                $display("FAIL signed_len%0d: got %h want %h", len, last_out, {16'h0000, 16'h0000, 16'hFFC8, 16'h0008});
            end
        end
    endtask

    task automatic test_backpressure;
        fill_random(2);
        run_job(2, 1'($urandom), 1'b0, 5);
    endtask

    task automatic test_bubbles;
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        foreach (pat[k]) q_pat.push_back(pat[k]);
        for (int k = 0; k < 4; k++) begin
            q_a.push_back({LANES{4'h1}});
            q_b.push_back({LANES{4'h1}});
        end
        run_job(4, 1'b0, 1'b0, 0);
        checks++;
        if (last_out !== {LANES{16'h0004}}) begin
            errors++;
            $display("FAIL bubbles: got %h want %h", last_out, {LANES{16'h0004}});
        end
    endtask

    task automatic test_reset_mid;
        // Two of four beats, then reset with a beat on the bus.
        acc_len = LEN_BW'(4); a_signed = 1'b0;
        a = {LANES{4'h3}}; b = {LANES{4'h3}};
        in_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: busy=%b out_valid=%b out=%h in_ready=%b want 0 0 0 1", busy, out_valid, out, in_ready);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        q_a.push_back({LANES{4'h2}});
        q_b.push_back({LANES{4'h2}});
        run_job(1, 1'b0, 1'b0, 0);
        checks++;
        if (last_out !== {LANES{16'h0004}}) begin
            errors++;
            $display("FAIL fresh_after_reset: got %h want %h", last_out, {LANES{16'h0004}});
        end

        // Reset while a result is waiting in DONE.
        acc_len = LEN_BW'(1);
        a = {LANES{4'h5}}; b = {LANES{4'h3}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_before_reset: out_valid=%b want 1", out_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_done: out_valid=%b out=%h busy=%b want 0 0 0", out_valid, out, busy);
        end
    endtask

    task automatic test_psum8;
        for (int k = 0; k < 2; k++) begin
            q_a.push_back({LANES{4'hF}});
            q_b.push_back({LANES{4'h7}});
        end
        run_job(2, 1'b0, 1'b0, 0);
`ifdef MAC_SATURATE_EN
        checks++;
        if (last_out8 !== {LANES{8'h7F}} || last_sat8 !== {LANES{1'b1}}) begin
            errors++;
            $display("FAIL psum8_sat: got %h sat %b want %h sat 1111", last_out8, last_sat8, {LANES{8'h7F}});
        end
`else
        checks++;
        if (last_out8 !== {LANES{8'hD2}}) begin
            errors++;
            $display("FAIL psum8_wrap: got %h want %h", last_out8, {LANES{8'hD2}});
        end
`endif
    endtask

    task automatic test_max_len;
        fill_random(255);
        run_job(255, 1'($urandom), 1'b0, 0);
    endtask

    task automatic test_random;
        for (int j = 0; j < 25; j++) begin
            int len;
            len = $urandom_range(0, 12);
            fill_random((len == 0) ? 1 : len);
            run_job(len, 1'($urandom), 1'b1, $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_signed = 1'b0; acc_len = '0; a = '0; b = '0;
        test_reset();
        test_unsigned_len3();
        test_signed_len1();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_psum8();
        test_max_len();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
